// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the framed serial-in/parallel-out receiver:
// FSM state encoding and the start/stop line levels.
package sipo_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2
  } sipo_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_deserializer.sv
// Framed serial-in/parallel-out receiver: start bit, DW data bits MSB first,
// stop bit, all on a strobed bit stream, with a valid/ready output handshake.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk_50MHz_i,
  input  logic          rst_async_la_i,
  input  logic          D_i,
  input  logic          Enable_i,
  input  logic          Ready_i,
  output logic [DW-1:0] Data_o,
  output logic          Valid_o,
  output logic          FrameErr_o,
  output logic          Overrun_o,
  output logic          Busy_o
);

  localparam int CW = $clog2(DW + 1);

  sipo_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] shreg;

  logic start_hit;
  logic shift_hit;
  logic last_bit;
  logic stop_good;
  logic stop_bad;
  logic accept;
  logic drop;

  always_comb begin
    state_nxt = state;
    start_hit = 1'b0;
    shift_hit = 1'b0;
    last_bit  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (Enable_i) begin
      unique case (state)
        ST_IDLE: begin
          if (D_i == START_BIT) begin
            start_hit = 1'b1;
            state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_hit = 1'b1;
          last_bit  = (cnt == CW'(DW - 1));
          if (last_bit) state_nxt = ST_STOP;
        end
        ST_STOP: begin
          stop_good = (D_i == STOP_BIT);
          stop_bad  = (D_i != STOP_BIT);
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A held word may be replaced only if the consumer takes it this same cycle.
  assign accept = stop_good && (!Valid_o || Ready_i);
  assign drop   = stop_good && Valid_o && !Ready_i;

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      if (start_hit) begin
        cnt <= '0;
      end else if (shift_hit) begin
        cnt   <= cnt + 1'b1;
        shreg <= {shreg[DW-2:0], D_i};
      end
    end
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      Data_o     <= '0;
      Valid_o    <= 1'b0;
      FrameErr_o <= 1'b0;
      Overrun_o  <= 1'b0;
    end else begin
      FrameErr_o <= stop_bad;
      if (drop) Overrun_o <= 1'b1;
      if (accept) begin
        Data_o  <= shreg;
        Valid_o <= 1'b1;
      end else if (Valid_o && Ready_i) begin
        Valid_o <= 1'b0;
      end
    end
  end

  assign Busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer against a frame-level
// reference model that collects strobed bits in a queue.
module tb_sipo_deserializer;

  localparam int DW = 4;

  logic          clk_50MHz_i = 1'b0;
  logic          rst_async_la_i = 1'b0;
  logic          D_i = 1'b0;
  logic          Enable_i = 1'b0;
  logic          Ready_i = 1'b0;
  logic [DW-1:0] Data_o;
  logic          Valid_o;
  logic          FrameErr_o;
  logic          Overrun_o;
  logic          Busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  sipo_deserializer #(.DW(DW)) dut (
    .clk_50MHz_i    (clk_50MHz_i),
    .rst_async_la_i (rst_async_la_i),
    .D_i            (D_i),
    .Enable_i       (Enable_i),
    .Ready_i        (Ready_i),
    .Data_o         (Data_o),
    .Valid_o        (Valid_o),
    .FrameErr_o     (FrameErr_o),
    .Overrun_o      (Overrun_o),
    .Busy_o         (Busy_o)
  );

  always #10 clk_50MHz_i = ~clk_50MHz_i;

  // Reference model: frame-level view of the receiver.
  bit       m_in_frame;
  bit       m_bits[$];
  int       m_data;
  bit       m_valid;
  bit       m_ferr;
  bit       m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_bits.delete();
    m_data  = 0;
    m_valid = 0;
    m_ferr  = 0;
    m_ovr   = 0;
  endtask

  task automatic model_clock(input bit en, input bit d, input bit rdy);
    bit v_before;
    int word;
    v_before = m_valid;
    m_ferr   = 0;
    if (v_before && rdy) m_valid = 0;
    if (en) begin
      if (!m_in_frame) begin
        if (d) begin
          m_in_frame = 1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == DW + 1) begin
          m_in_frame = 0;
          word = 0;
          for (int i = 0; i < DW; i++) word = word * 2 + int'(m_bits[i]);
          if (m_bits[DW] == 1'b0) begin
            if (!v_before || rdy) begin
              m_data  = word;
              m_valid = 1;
            end else begin
              m_ovr = 1;
            end
          end else begin
            m_ferr = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("data",     32'(Data_o),     32'(m_data));
    chk("valid",    32'(Valid_o),    32'(m_valid));
    chk("frameerr", 32'(FrameErr_o), 32'(m_ferr));
    chk("overrun",  32'(Overrun_o),  32'(m_ovr));
    chk("busy",     32'(Busy_o),     32'(m_in_frame));
  endtask

  task automatic step(input bit en, input bit d, input bit rdy);
    @(negedge clk_50MHz_i);
    Enable_i = en;
    D_i      = d;
    Ready_i  = rdy;
    @(posedge clk_50MHz_i);
    model_clock(en, d, rdy);
    #1;
    compare_all();
  endtask

  // One strobed bit, preceded by `gap` non-strobe cycles carrying junk on D_i.
  task automatic strobe(input bit d, input bit rdy, input int gap);
    for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), rdy);
    step(1'b1, d, rdy);
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input bit stop, input bit rdy,
                            input bit rdy_stop, input int gap);
    logic [DW-1:0] wv;
    wv = w;
    strobe(1'b1, rdy, gap);
    for (int i = DW - 1; i >= 0; i--) strobe(wv[i], rdy, gap);
    strobe(stop, rdy_stop, gap);
  endtask

  task automatic apply_reset();
    @(negedge clk_50MHz_i);
    #3;
    rst_async_la_i = 1'b0;
    #1;
    model_reset();
    chk("rst_data",  32'(Data_o),     32'd0);
    chk("rst_valid", 32'(Valid_o),    32'd0);
    chk("rst_ferr",  32'(FrameErr_o), 32'd0);
    chk("rst_ovr",   32'(Overrun_o),  32'd0);
    chk("rst_busy",  32'(Busy_o),     32'd0);
    @(negedge clk_50MHz_i);
    rst_async_la_i = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_50MHz_i);
    #1;
    compare_all();
    @(negedge clk_50MHz_i);
    rst_async_la_i = 1'b1;

    // Good frame 4'hA, valid for one cycle with Ready_i high.
    send_frame(4'hA, 1'b0, 1'b1, 1'b1, 0);
    chk("a_data",  32'(Data_o),  32'hA);
    chk("a_valid", 32'(Valid_o), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("a_valid_clr", 32'(Valid_o), 32'd0);

    // Bad stop bit: single-cycle FrameErr_o, no delivery.
    send_frame(4'h6, 1'b1, 1'b1, 1'b1, 0);
    chk("fe_pulse", 32'(FrameErr_o), 32'd1);
    chk("fe_valid", 32'(Valid_o),    32'd0);
    chk("fe_busy",  32'(Busy_o),     32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("fe_clear", 32'(FrameErr_o), 32'd0);

    // Two frames with no consumer: first kept, second dropped.
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 0);
    send_frame(4'hC, 1'b0, 1'b0, 1'b0, 0);
    chk("ovr_data", 32'(Data_o),    32'h3);
    chk("ovr_flag", 32'(Overrun_o), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr_vclr", 32'(Valid_o),   32'd0);
    chk("ovr_stky", 32'(Overrun_o), 32'd1);

    // Consumer takes the old word in the same cycle as the new stop strobe.
    apply_reset();
    send_frame(4'h7, 1'b0, 1'b0, 1'b0, 0);
    send_frame(4'h2, 1'b0, 1'b0, 1'b1, 0);
    chk("swap_data",  32'(Data_o),    32'h2);
    chk("swap_valid", 32'(Valid_o),   32'd1);
    chk("swap_ovr",   32'(Overrun_o), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // Sparse strobe: every third cycle.
    send_frame(4'h5, 1'b0, 1'b1, 1'b1, 2);
    chk("sparse_data",  32'(Data_o),  32'h5);
    chk("sparse_valid", 32'(Valid_o), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // Reset after two data bits, then a clean frame.
    strobe(1'b1, 1'b1, 0);
    strobe(1'b1, 1'b1, 0);
    strobe(1'b0, 1'b1, 0);
    apply_reset();
    send_frame(4'h9, 1'b0, 1'b1, 1'b1, 0);
    chk("post_rst_data",  32'(Data_o),  32'h9);
    chk("post_rst_valid", 32'(Valid_o), 32'd1);

    // Random traffic: idle zeros, gaps, random ready, occasional bad stop.
    for (int f = 0; f < 150; f++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++)
        step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      strobe(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
      for (int b = 0; b < DW; b++)
        strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      strobe(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 1));
      if (f == 75) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter DW, default 4, giving the data word width in bits; legal range 2..32.
REQ-002 SHALL have port clk_50MHz_i, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_async_la_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port D_i, input, 1 bit: serial line data, sampled only when Enable_i=1.
REQ-005 SHALL have port Enable_i, input, 1 bit: bit strobe; one serial bit per cycle with Enable_i=1.
REQ-006 SHALL have port Ready_i, input, 1 bit: consumer can accept Data_o.
REQ-007 SHALL have port Data_o, output, DW bits: last received word, MSB = first data bit received.
REQ-008 SHALL have port Valid_o, output, 1 bit: Data_o holds an unconsumed word.
REQ-009 SHALL have port FrameErr_o, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port Overrun_o, output, 1 bit: sticky flag, set when a received word is dropped.
REQ-011 SHALL have port Busy_o, output, 1 bit: 1 while in SHIFT or STOP.

Function
REQ-012 SHALL receive frames on the strobed bit stream: start bit '1', then DW data bits MSB first, then stop bit '0'.
REQ-013 SHALL implement FSM states IDLE, SHIFT and STOP; with Enable_i=0 the FSM, counter and shift register SHALL hold.
REQ-014 IDLE: strobed D_i=1 SHALL go to SHIFT with the bit counter cleared; strobed D_i=0 SHALL stay in IDLE.
REQ-015 SHIFT: each strobe SHALL shift D_i into the shift register LSB and increment the counter; the DW-th strobe SHALL go to STOP.
REQ-016 STOP, strobed D_i=0: SHALL deliver the word per REQ-018/019 and go to IDLE.
REQ-017 STOP, strobed D_i=1: SHALL discard the word, pulse FrameErr_o for exactly one cycle, leave Data_o, Valid_o and Overrun_o unchanged, and go to IDLE.
REQ-018 Delivery: if Valid_o=0, or Valid_o=1 and Ready_i=1 in the same cycle, SHALL load Data_o and drive Valid_o=1 on the next cycle.
REQ-019 Delivery with Valid_o=1 and Ready_i=0: SHALL drop the new word, keep Data_o, and set Overrun_o.
REQ-020 Handshake: a cycle with Valid_o=1 and Ready_i=1 and no simultaneous delivery SHALL clear Valid_o on the next cycle.
REQ-021 Data_o SHALL remain stable while Valid_o=1 and Ready_i=0.
REQ-022 Latency: Valid_o SHALL rise in the cycle immediately after the stop-bit strobe cycle.
REQ-023 Overrun_o SHALL remain set until reset.
REQ-024 Busy_o SHALL be a registered or decoded function of the FSM state only.

Reset
REQ-025 rst_async_la_i=0 SHALL immediately force: FSM to IDLE, counter=0, shift register=0, Data_o=0, Valid_o=0, FrameErr_o=0, Overrun_o=0, Busy_o=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no Valid_o or FrameErr_o.
REQ-027 After reset release, the block SHALL accept a start bit on the first strobe.

Structure
REQ-028 State encodings (IDLE/SHIFT/STOP) and the start/stop bit level constants SHALL reside in shared package sipo_deserializer_pkg.
REQ-029 The bit counter width SHALL be $clog2(DW+1) and SHALL never wrap within a frame.
REQ-030 The design SHALL be a single module with no sub-modules.

Verification
REQ-031 DW=4, Ready_i=1, strobed bits 1,1,0,1,0,0 -> Data_o=4'hA and Valid_o=1 for one cycle, FrameErr_o=0.
REQ-032 DW=4, bits 1,0,1,1,0,1 -> FrameErr_o pulses once, Valid_o stays 0, FSM returns to IDLE.
REQ-033 Ready_i=0, two good frames 4'h3 then 4'hC -> Data_o=4'h3 held, Overrun_o=1; Ready_i=1 -> Valid_o clears next cycle.
REQ-034 Valid_o=1 with Ready_i asserted in the same cycle as the next frame's stop strobe -> Data_o updates to the new word, Valid_o stays 1, Overrun_o=0.
REQ-035 Enable_i toggled every 3rd cycle through frame 4'h5 -> same result as a continuous strobe; no state change on non-strobe cycles.
REQ-036 Reset pulsed after 2 data bits -> all outputs 0; a following frame 4'h9 is received correctly.
